// File: rtl/nzcv_flag_unit_pkg.sv
// flag_pkg: shared types for the NZCV flag producer.
//   alu_op_t  - execute-stage op class (ADD/SUB/RSB/LOGIC)
//   flags_t   - committed status flags {n,z,c,v}; gains a leading sticky q
//               bit when FLAG_STICKY_Q_EN is defined
//   FLAGS_RST - flag register / reset value
// Build option: FLAG_STICKY_Q_EN (sticky overflow flag Q).
package flag_pkg;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_RSB   = 2'd2,
        ALU_LOGIC = 2'd3
    } alu_op_t;

    typedef struct packed {
`ifdef FLAG_STICKY_Q_EN
        logic q;
`endif
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam flags_t FLAGS_RST = '0;

endpackage

// File: rtl/nzcv_flag_unit_if.sv
// nzcv_flag_unit_if: execute-stage update, stack control and flag outputs.
//   master - drives the update/stack requests, observes flags and stack status
//   slave  - the flag unit
//   inputs to the unit : upd_valid, set_flags, cond_pass, alu_op, op_a, op_b,
//                        result, shifter_carry, push, pop (+ clr_q)
//   outputs of the unit: N, Z, C, V, stack_full, stack_empty, stack_err (+ Q)
// Build option: FLAG_STICKY_Q_EN adds clr_q and Q.
interface nzcv_flag_unit_if
    import flag_pkg::*;
#(
    parameter int W = 32
);
    logic         upd_valid;
    logic         set_flags;
    logic         cond_pass;
    alu_op_t      alu_op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] result;
    logic         shifter_carry;
    logic         push;
    logic         pop;
    logic         N;
    logic         Z;
    logic         C;
    logic         V;
    logic         stack_full;
    logic         stack_empty;
    logic         stack_err;
`ifdef FLAG_STICKY_Q_EN
    logic         clr_q;
    logic         Q;
`endif

    modport master (
        output upd_valid, set_flags, cond_pass, alu_op, op_a, op_b, result,
               shifter_carry, push, pop,
        input  N, Z, C, V, stack_full, stack_empty, stack_err
`ifdef FLAG_STICKY_Q_EN
        , output clr_q
        , input  Q
`endif
    );

    modport slave (
        input  upd_valid, set_flags, cond_pass, alu_op, op_a, op_b, result,
               shifter_carry, push, pop,
        output N, Z, C, V, stack_full, stack_empty, stack_err
`ifdef FLAG_STICKY_Q_EN
        , input  clr_q
        , output Q
`endif
    );

endinterface

// File: rtl/nzcv_flag_unit_calc.sv
// nzcv_calc: combinational next-flag computation.
//   in : op_a, op_b, result (W bits), alu_op, shifter_carry, v_prev
//   out: n, z, c, v (+ arith_v = V of an arithmetic op, for sticky Q)
// The supplied ALU result is trusted; nothing is recomputed except carry.
// Build option: FLAG_STICKY_Q_EN adds arith_v.
module nzcv_calc
    import flag_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [W-1:0] result,
    input  alu_op_t      alu_op,
    input  logic         shifter_carry,
    input  logic         v_prev,
`ifdef FLAG_STICKY_Q_EN
    output logic         arith_v,
`endif
    output logic         n,
    output logic         z,
    output logic         c,
    output logic         v
);
    logic sa, sb, sr;
    logic add_c;

    assign sa = op_a[W-1];
    assign sb = op_b[W-1];
    assign sr = result[W-1];

    // a + b carries out of W bits exactly when a > (2^W-1-b) = ~b.
    assign add_c = (op_a > ~op_b);

    always_comb begin
        n = sr;
        z = (result == '0);
        c = shifter_carry;
        v = v_prev;
        unique case (alu_op)
            ALU_ADD: begin
                c = add_c;
                v = (sa == sb) & (sr != sa);
            end
            ALU_SUB: begin
                c = (op_a >= op_b);
                v = (sa != sb) & (sr != sa);
            end
            ALU_RSB: begin
                c = (op_b >= op_a);
                v = (sb != sa) & (sr != sb);
            end
            default: begin
                c = shifter_carry;
                v = v_prev;
            end
        endcase
    end

`ifdef FLAG_STICKY_Q_EN
    assign arith_v = (alu_op != ALU_LOGIC) & v;
`endif

endmodule

// File: rtl/nzcv_flag_unit.sv
// nzcv_flag_unit: NZCV status register with a LIFO shadow stack.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - nzcv_flag_unit_if.slave (update request, push/pop, flags,
//                stack_full/stack_empty/stack_err)
// Flags commit one cycle after upd_valid & set_flags & cond_pass. A pop
// restores the top stack entry and overrides a same-cycle update; a push
// saves the pre-update flags. Conflicts, overflow and underflow are ignored
// and reported as a one-cycle stack_err pulse.
// Build option: FLAG_STICKY_Q_EN adds sticky overflow Q and clr_q.
module nzcv_flag_unit
    import flag_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    nzcv_flag_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    flags_t          flags, flags_nxt;
    flags_t          stk [DEPTH];
    logic [CW-1:0]   cnt, cnt_nxt, cnt_m1;
    logic            err, err_nxt;
    logic            full, empty, upd, do_push, do_pop;
    logic            c_n, c_z, c_c, c_v;
`ifdef FLAG_STICKY_Q_EN
    logic            c_av;
`endif

    nzcv_calc #(.W(W)) u_calc (
        .op_a          (bus.op_a),
        .op_b          (bus.op_b),
        .result        (bus.result),
        .alu_op        (bus.alu_op),
        .shifter_carry (bus.shifter_carry),
        .v_prev        (flags.v),
`ifdef FLAG_STICKY_Q_EN
        .arith_v       (c_av),
`endif
        .n             (c_n),
        .z             (c_z),
        .c             (c_c),
        .v             (c_v)
    );

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign cnt_m1  = cnt - CW'(1);
    assign upd     = bus.upd_valid & bus.set_flags & bus.cond_pass;
    assign do_push = bus.push & ~bus.pop & ~full;
    assign do_pop  = bus.pop & ~bus.push & ~empty;
    assign err_nxt = (bus.push & bus.pop) | (bus.push & ~bus.pop & full) |
                     (bus.pop & ~bus.push & empty);

    always_comb begin
        flags_nxt = flags;
        if (do_pop) begin
            flags_nxt = stk[cnt_m1[AW-1:0]];
        end else if (upd) begin
            flags_nxt.n = c_n;
            flags_nxt.z = c_z;
            flags_nxt.c = c_c;
            flags_nxt.v = c_v;
`ifdef FLAG_STICKY_Q_EN
            if (c_av) flags_nxt.q = 1'b1;
`endif
        end
`ifdef FLAG_STICKY_Q_EN
        if (bus.clr_q) flags_nxt.q = 1'b0;
`endif
    end

    always_comb begin
        cnt_nxt = cnt;
        if (do_push)     cnt_nxt = cnt + CW'(1);
        else if (do_pop) cnt_nxt = cnt_m1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags <= FLAGS_RST;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            flags <= flags_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
        end
    end

    // Stack storage needs no reset; only the count defines valid entries.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) stk[cnt[AW-1:0]] <= flags;
    end

    assign bus.N           = flags.n;
    assign bus.Z           = flags.z;
    assign bus.C           = flags.c;
    assign bus.V           = flags.v;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_err   = err;
`ifdef FLAG_STICKY_Q_EN
    assign bus.Q           = flags.q;
`endif

endmodule

// File: doc/nzcv_flag_unit.md
Name: nzcv_flag_unit

Overview:
Producer side of the processor's NZCV status flags, which the condition evaluator consumes.
- Computes N, Z, C, V from the execute-stage ALU operands, result and op class.
- Commits the flags to a status register when the instruction has its S bit set and its condition passed.
- Keeps a small LIFO shadow stack so flags can be saved and restored around exceptions and interrupts.

Parameters:
W, 32, datapath width of operands and result
DEPTH, 4, shadow stack entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset
upd_valid  in  1  execute-stage instruction valid this cycle
set_flags  in  1  instruction S bit
cond_pass  in  1  condition evaluation result for this instruction
alu_op  in  2  op class: ADD=0, SUB=1, RSB=2, LOGIC=3
op_a  in  W  ALU operand A
op_b  in  W  ALU operand B (post-shifter)
result  in  W  ALU result
shifter_carry  in  1  barrel-shifter carry-out, used for LOGIC
push  in  1  save current flags to stack
pop  in  1  restore flags from stack
N, Z, C, V  out  1 each  committed flags
stack_full  out  1  count==DEPTH
stack_empty  out  1  count==0
stack_err  out  1  one-cycle pulse on overflow, underflow or push+pop conflict

Behaviour:
- Clock and reset: single clock `clk`. `rst_n` is synchronous and active-low.
- Reset values: N=Z=C=V=0; stack count=0; stack_empty=1; stack_full=0; stack_err=0. Stack contents are don't-care.
- Reset mid-operation: any pending push/pop/update in the reset cycle is discarded.
- Commit condition: `upd = upd_valid & set_flags & cond_pass`. Flags are registered, latency 1: values computed in cycle t are visible on N/Z/C/V after edge t+1. When upd=0, the flags hold.
- N = result[W-1] for all op classes.
- Z = (result == 0) for all op classes.
- ADD:
  - C = bit W of the (W+1)-bit sum {0,op_a} + {0,op_b}.
  - V = (op_a[W-1]==op_b[W-1]) & (result[W-1]!=op_a[W-1]).
- SUB (a-b):
  - C = (op_a >= op_b) unsigned, i.e. NOT borrow.
  - V = (op_a[W-1]!=op_b[W-1]) & (result[W-1]!=op_a[W-1]).
- RSB (b-a): same as SUB with op_a and op_b swapped in the C and V equations.
- LOGIC: C = shifter_carry; V holds its previous value.
- Flag computation uses the supplied `result`; the unit does not recompute the ALU result.
- Push (push=1, pop=0, not full):
  - stack[count] <= current registered flags (the pre-update value, even if upd=1 the same cycle); count++.
  - An update in the same cycle still commits.
- Pop (pop=1, push=0, not empty):
  - flags <= stack[count-1]; count--.
  - The pop takes priority over upd; a same-cycle update is discarded.
- push & pop the same cycle: stack unchanged; stack_err=1 next cycle; upd commits normally.
- Push when full: ignored; stack_err=1 next cycle.
- Pop when empty: ignored; flags follow upd; stack_err=1 next cycle.
- stack_err is a registered single-cycle pulse and is 0 otherwise.
- stack_full and stack_empty are decoded from the registered count.
- No wrap-around: count saturates at 0 and DEPTH.

Optional Feature:
FLAG_STICKY_Q_EN
- Defined:
  - Adds output `Q` (1) and input `clr_q` (1).
  - Q is set on any committed ADD/SUB/RSB update whose computed V=1. It is cleared by clr_q=1 (clr_q wins over set) or reset.
  - Stack entries widen to 5 bits; Q is pushed and popped with NZCV.
- Undefined: the Q and clr_q ports are absent, stack entries are 4 bits, and behaviour is otherwise identical.

Decomposition:
- Package `flag_pkg` holds:
  - the `alu_op_t` enum (ADD/SUB/RSB/LOGIC);
  - the `flags_t` packed struct {n,z,c,v} (plus q when the macro is defined);
  - the flags reset constant FLAGS_RST.
- Sub-module `nzcv_calc`: purely combinational next-flag computation from op_a, op_b, result, alu_op, shifter_carry and previous V.
- The top level holds the status register, the stack array, the counter and the arbitration logic.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001, result 0x80000000, upd=1 -> next cycle N=1, Z=0, C=0, V=1.
- SUB 5-5 (result 0) -> Z=1, C=1, N=0, V=0. Then SUB 3-5 (result 0xFFFFFFFE) -> N=1, Z=0, C=0, V=0.
- Gating: LOGIC result 0 with cond_pass=0, then again with set_flags=0 -> flags unchanged both cycles.
- LOGIC with shifter_carry=1 and prior V=1 -> C=1, V=1 held.
- Stack overflow and LIFO order: push 4 distinct flag values (DEPTH=4) -> stack_full=1. A 5th push -> stack_err pulse, count stays 4. Four pops restore the values in reverse order, then stack_empty=1.
- Pop and reset conflicts:
  - pop with upd=1 the same cycle -> flags equal the popped value.
  - pop on empty -> stack_err=1, flags take the update.
  - rst_n=0 with count=2 -> next edge count=0, flags=0000.
